// File: rtl/ceres_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ceres_ram_arbiter
// Purpose  : Round-robin two-master sequencer sharing a single RAM port.
//            Optional macro RAM_ARB_STATS_EN adds grant/wait counters.
// Revision : 1.0
// ============================================================================
module ceres_ram_arbiter #(
    parameter  int LINE_W      = 128,
    parameter  int RAM_DEPTH   = 262144,
    parameter  int RAM_LATENCY = 16,
    localparam int STRB_W      = LINE_W / 8,
    localparam int AW          = $clog2(RAM_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_valid_i,
    input  logic [31:0]       m0_addr_i,
    input  logic [LINE_W-1:0] m0_wdata_i,
    input  logic [STRB_W-1:0] m0_wstrb_i,
    output logic              m0_res_valid_o,
    output logic [LINE_W-1:0] m0_res_data_o,
    input  logic              m1_valid_i,
    input  logic [31:0]       m1_addr_i,
    input  logic [LINE_W-1:0] m1_wdata_i,
    input  logic [STRB_W-1:0] m1_wstrb_i,
    output logic              m1_res_valid_o,
    output logic [LINE_W-1:0] m1_res_data_o,
    output logic [AW-1:0]     ram_addr_o,
    output logic [LINE_W-1:0] ram_wdata_o,
    output logic [STRB_W-1:0] ram_wstrb_o,
    output logic              ram_rd_en_o,
    input  logic [LINE_W-1:0] ram_rdata_i,
`ifdef RAM_ARB_STATS_EN
    output logic [31:0]       m0_grants_o,
    output logic [31:0]       m1_grants_o,
    output logic [31:0]       wait_cycles_o,
`endif
    output logic              busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                last_grant_q, last_grant_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [7:0]          cnt_q, cnt_d;

    // Byte-lane and above-range address bits carry no meaning for the RAM.
    logic w_unused;
    assign w_unused = &{1'b0, m0_addr_i[31:AW+2], m0_addr_i[1:0],
                        m1_addr_i[31:AW+2], m1_addr_i[1:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        last_grant_d   = last_grant_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        wstrb_d        = wstrb_q;
        cnt_d          = cnt_q;
        ram_wstrb_o    = '0;
        ram_rd_en_o    = 1'b0;
        m0_res_valid_o = 1'b0;
        m0_res_data_o  = '0;
        m1_res_valid_o = 1'b0;
        m1_res_data_o  = '0;
        case (state_q)
            S_IDLE: begin
                if (m0_valid_i || m1_valid_i) begin
                    // On a tie the port that did not win last time is served.
                    gnt_d        = (m0_valid_i && m1_valid_i) ? ~last_grant_q : m1_valid_i;
                    last_grant_d = gnt_d;
                    addr_d       = gnt_d ? m1_addr_i[AW+1:2] : m0_addr_i[AW+1:2];
                    wdata_d      = gnt_d ? m1_wdata_i : m0_wdata_i;
                    wstrb_d      = gnt_d ? m1_wstrb_i : m0_wstrb_i;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ram_wstrb_o = wstrb_q;
                ram_rd_en_o = ~|wstrb_q;
                cnt_d       = 8'(RAM_LATENCY - 1);
                state_d     = (RAM_LATENCY == 1) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (gnt_q) begin
                    m1_res_valid_o = 1'b1;
                    m1_res_data_o  = ram_rdata_i;
                end else begin
                    m0_res_valid_o = 1'b1;
                    m0_res_data_o  = ram_rdata_i;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = wdata_q;
    assign busy_o      = (state_q != S_IDLE);

`ifdef RAM_ARB_STATS_EN
    logic [31:0] m0_grants_q, m1_grants_q, wait_cycles_q;
    logic        w_wait_inc;
    logic        w_grant;

    assign w_grant    = (state_q == S_IDLE) && (state_d == S_ISSUE);
    // Idle: a tie leaves one requester waiting; busy: the other port waits.
    assign w_wait_inc = (state_q == S_IDLE) ? (m0_valid_i && m1_valid_i)
                                            : (gnt_q ? m0_valid_i : m1_valid_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m0_grants_q   <= '0;
            m1_grants_q   <= '0;
            wait_cycles_q <= '0;
        end else begin
            if (w_grant && !gnt_d) m0_grants_q <= m0_grants_q + 32'd1;
            if (w_grant &&  gnt_d) m1_grants_q <= m1_grants_q + 32'd1;
            if (w_wait_inc)        wait_cycles_q <= wait_cycles_q + 32'd1;
        end
    end

    assign m0_grants_o   = m0_grants_q;
    assign m1_grants_o   = m1_grants_q;
    assign wait_cycles_o = wait_cycles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ceres_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ceres_ram_arbiter
// Purpose  : Randomized self-checking bench for ceres_ram_arbiter against a
//            transaction-schedule model; also checks a RAM_LATENCY=1 build.
// Revision : 1.0
// ============================================================================
module tb_ceres_ram_arbiter;
    localparam int LW   = 128;
    localparam int SW   = 16;
    localparam int AW   = 18;
    localparam int LAT  = 16;
    localparam int NCYC = 3000;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic              rst_i;
    logic              av  [2];
    logic [31:0]       aadr[2];
    logic [LW-1:0]     awd [2];
    logic [SW-1:0]     ast [2];
    logic [LW-1:0]     ram_rdata_i;
    logic              r0v, r1v, rd_en, busy;
    logic [LW-1:0]     r0d, r1d, ram_wdata;
    logic [SW-1:0]     ram_wstrb;
    logic [AW-1:0]     ram_addr;

    // Latency-1 instance signals
    logic              l_v0, l_v1;
    logic [SW-1:0]     l_st1;
    logic [LW-1:0]     l_wd1;
    logic              l_r0v, l_r1v, l_rd, l_busy;
    logic [LW-1:0]     l_r0d, l_r1d, l_wdo;
    logic [SW-1:0]     l_wso;
    logic [AW-1:0]     l_ao;

`ifdef RAM_ARB_STATS_EN
    logic [31:0] g0, g1, wc, l_g0, l_g1, l_wc;
`endif

    ceres_ram_arbiter #(.LINE_W(LW), .RAM_DEPTH(262144), .RAM_LATENCY(LAT)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_valid_i(av[0]), .m0_addr_i(aadr[0]), .m0_wdata_i(awd[0]), .m0_wstrb_i(ast[0]),
        .m0_res_valid_o(r0v), .m0_res_data_o(r0d),
        .m1_valid_i(av[1]), .m1_addr_i(aadr[1]), .m1_wdata_i(awd[1]), .m1_wstrb_i(ast[1]),
        .m1_res_valid_o(r1v), .m1_res_data_o(r1d),
        .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_wstrb_o(ram_wstrb),
        .ram_rd_en_o(rd_en), .ram_rdata_i(ram_rdata_i),
`ifdef RAM_ARB_STATS_EN
        .m0_grants_o(g0), .m1_grants_o(g1), .wait_cycles_o(wc),
`endif
        .busy_o(busy)
    );

    ceres_ram_arbiter #(.LINE_W(LW), .RAM_DEPTH(262144), .RAM_LATENCY(1)) u_dut_lat1 (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_valid_i(l_v0), .m0_addr_i(32'h0000_0020), .m0_wdata_i('0), .m0_wstrb_i('0),
        .m0_res_valid_o(l_r0v), .m0_res_data_o(l_r0d),
        .m1_valid_i(l_v1), .m1_addr_i(32'h0000_0040), .m1_wdata_i(l_wd1), .m1_wstrb_i(l_st1),
        .m1_res_valid_o(l_r1v), .m1_res_data_o(l_r1d),
        .ram_addr_o(l_ao), .ram_wdata_o(l_wdo), .ram_wstrb_o(l_wso),
        .ram_rd_en_o(l_rd), .ram_rdata_i(ram_rdata_i),
`ifdef RAM_ARB_STATS_EN
        .m0_grants_o(l_g0), .m1_grants_o(l_g1), .wait_cycles_o(l_wc),
`endif
        .busy_o(l_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Transaction-level model: one outstanding access described by its
    // issue cycle and response cycle.
    logic          mb, mg, mlast, prev_rst, hold;
    int            mic, mrc, nrst;
    logic [AW-1:0] ma;
    logic [LW-1:0] mwd;
    logic [SW-1:0] mst;
    logic          drop[2];
    int unsigned   eg0, eg1, ewc;
    logic          e_r0v, e_r1v;
    logic [LW-1:0] e_r0d, e_r1d;

    task automatic new_req(input int p);
        av[p]   = 1'b1;
        aadr[p] = $urandom;
        awd[p]  = {$urandom, $urandom, $urandom, $urandom};
        ast[p]  = ($urandom_range(0, 1) == 0) ? '0 : SW'($urandom);
    endtask

    initial begin
        rst_i = 1'b1;
        for (int p = 0; p < 2; p++) begin
            av[p] = 1'b0; aadr[p] = '0; awd[p] = '0; ast[p] = '0; drop[p] = 1'b0;
        end
        l_v0 = 1'b0; l_v1 = 1'b0; l_st1 = '0; l_wd1 = '0;
        ram_rdata_i = '0;
        mb = 1'b0; mg = 1'b0; mlast = 1'b1; prev_rst = 1'b1; hold = 1'b0;
        mic = 0; mrc = 0; nrst = 0; ma = '0; mwd = '0; mst = '0;
        eg0 = 0; eg1 = 0; ewc = 0;

        for (int t = 0; t < NCYC; t++) begin
            @(posedge clk_i);
            #1;
            // ---------------- drive cycle t ----------------
            rst_i = (t < 2);
            if (t >= 60 && mb && t == mic + 7 && (nrst == 0 || (t >= 300 && nrst < 5 && $urandom_range(0, 2) == 0))) begin
                rst_i = 1'b1;
                nrst++;
            end
            ram_rdata_i = {$urandom, $urandom, $urandom, $urandom};
            for (int p = 0; p < 2; p++) begin
                if (drop[p]) begin
                    drop[p] = 1'b0;
                    if (hold) new_req(p);
                    else      av[p] = 1'b0;
                end else if (!av[p] && t >= 300 && $urandom_range(0, 3) == 0) begin
                    new_req(p);
                end
            end
            if (t == 2) begin
                av[0] = 1'b1; aadr[0] = 32'h8000_0010; awd[0] = '0; ast[0] = '0;
            end
            if (t == 25) begin
                av[1] = 1'b1; aadr[1] = 32'h0000_1234; awd[1] = {16{8'hA5}}; ast[1] = 16'hFFFF;
            end
            if (t == 50) begin
                hold = 1'b1; new_req(0); new_req(1);
            end
            if (t == 300) hold = 1'b0;
            if (t == 2)  l_v0 = 1'b1;
            if (t == 5)  l_v0 = 1'b0;
            if (t == 10) begin l_v1 = 1'b1; l_st1 = 16'hFFFF; l_wd1 = {4{$urandom}}; end
            if (t == 13) l_v1 = 1'b0;

            @(negedge clk_i);
            // ---------------- check cycle t ----------------
            if (prev_rst) begin
                mb = 1'b0; mlast = 1'b1; eg0 = 0; eg1 = 0; ewc = 0;
            end
            e_r0v = 1'b0; e_r1v = 1'b0; e_r0d = '0; e_r1d = '0;
            if (mb && t == mrc) begin
                if (mg) begin e_r1v = 1'b1; e_r1d = ram_rdata_i; end
                else    begin e_r0v = 1'b0 | 1'b1; e_r0d = ram_rdata_i; end
            end
            chk("busy", busy, mb);
            chk("rd_en", rd_en, mb && t == mic && mst == '0);
            chk("wstrb", ram_wstrb, (mb && t == mic) ? mst : '0);
            chk("m0_res_valid", r0v, e_r0v);
            chk("m1_res_valid", r1v, e_r1v);
            chk("m0_res_data", r0d, e_r0d);
            chk("m1_res_data", r1d, e_r1d);
            if (mb && t == mic) begin
                chk("ram_addr", ram_addr, ma);
                chk("ram_wdata", ram_wdata, mwd);
            end
            if (t == 0) begin
                chk("reset_addr", ram_addr, '0);
                chk("reset_wdata", ram_wdata, '0);
            end
`ifdef RAM_ARB_STATS_EN
            chk("m0_grants", g0, eg0);
            chk("m1_grants", g1, eg1);
            chk("wait_cycles", wc, ewc);
`endif
            case (t)
                2:  chk("lat1_idle_busy", l_busy, 1'b0);
                3:  begin chk("lat1_issue_rd", l_rd, 1'b1); chk("lat1_issue_res", l_r0v, 1'b0); end
                4:  begin chk("lat1_resp_valid", l_r0v, 1'b1); chk("lat1_resp_data", l_r0d, ram_rdata_i);
                          chk("lat1_resp_rd", l_rd, 1'b0); end
                5:  begin chk("lat1_back_idle", l_busy, 1'b0); chk("lat1_no_res", l_r0v, 1'b0); end
                11: begin chk("lat1_wr_strb", l_wso, 16'hFFFF); chk("lat1_wr_rd", l_rd, 1'b0);
                          chk("lat1_wr_data", l_wdo, l_wd1); end
                12: begin chk("lat1_wr_resp", l_r1v, 1'b1); chk("lat1_wr_resp_m0", l_r0v, 1'b0); end
                13: chk("lat1_wr_idle", l_busy, 1'b0);
                default: ;
            endcase

            if (e_r0v) drop[0] = 1'b1;
            if (e_r1v) drop[1] = 1'b1;

            // ---------------- advance model past cycle t ----------------
            if (!rst_i) begin
                if (mb) begin
                    if (mg ? av[0] : av[1]) ewc++;
                    if (t == mrc) mb = 1'b0;
                end else if (av[0] || av[1]) begin
                    if (av[0] && av[1]) ewc++;
                    mg    = (av[0] && av[1]) ? ~mlast : av[1];
                    mlast = mg;
                    mb    = 1'b1;
                    mic   = t + 1;
                    mrc   = t + 1 + LAT;
                    ma    = aadr[mg][AW+1:2];
                    mwd   = awd[mg];
                    mst   = ast[mg];
                    if (mg) eg1++;
                    else    eg0++;
                end
            end
            prev_rst = rst_i;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
